friscv_fetch_unit: RTL and testbench
====================================

FRISCV_FETCH_UNIT -- requirements
Module: friscv_fetch_unit

Interface
REQ-001 SHALL have parameter ARCH, default 32, meaning address/instruction width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning prefetch buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset; bits [1:0] = 0.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port fetch_en_in  input  1  permits issuing new memory requests.
REQ-007 SHALL have port imem_req_out  output  1  instruction memory request valid.
REQ-008 SHALL have port imem_addr_out  output  ARCH  request word address.
REQ-009 SHALL have port imem_gnt_in  input  1  request accepted this cycle.
REQ-010 SHALL have port imem_rvalid_in  input  1  response data valid.
REQ-011 SHALL have port imem_rdata_in  input  ARCH  response instruction word.
REQ-012 SHALL have port redirect_in  input  1  branch/jump taken; flush and refetch.
REQ-013 SHALL have port redirect_addr_in  input  ARCH  new fetch target.
REQ-014 SHALL have port instr_valid_out  output  1  instr_out/instr_pc_out valid.
REQ-015 SHALL have port instr_ready_in  input  1  decode stage accepts instruction.
REQ-016 SHALL have port instr_out  output  ARCH  fetched instruction.
REQ-017 SHALL have port instr_pc_out  output  ARCH  address of instr_out.

Function
REQ-018 SHALL implement states IDLE, RUN, FLUSH; IDLE->RUN when fetch_en_in=1; RUN->IDLE when fetch_en_in=0 and outstanding=0; any state->FLUSH on redirect_in=1 with outstanding responses not returning that cycle; FLUSH->RUN (or IDLE if fetch_en_in=0) when discard count reaches 0; redirect with nothing outstanding -> RUN/IDLE directly.
REQ-019 SHALL assert imem_req_out only in RUN, with fetch_en_in=1, redirect_in=0, and (FIFO occupancy + outstanding) < FIFO_DEPTH.
REQ-020 SHALL hold imem_addr_out stable while imem_req_out=1 and imem_gnt_in=0; a request is withdrawn only by redirect_in or fetch_en_in=0.
REQ-021 SHALL on req&&gnt increment fetch PC by 4 (modulo 2^ARCH, wrap 0xFFFFFFFC->0) and increment outstanding count.
REQ-022 SHALL accept responses strictly in request order, one per cycle, earliest the cycle after grant; gnt and rvalid for different requests may coincide.
REQ-023 SHALL on rvalid in RUN push {pc, rdata} into FIFO; pc is the address of the oldest outstanding request; outstanding decrements.
REQ-024 SHALL present FIFO head on instr_out/instr_pc_out with instr_valid_out = FIFO non-empty; rvalid in cycle N -> instr_valid_out no earlier than N+1 (no bypass).
REQ-025 SHALL pop FIFO when instr_valid_out && instr_ready_in; simultaneous push and pop SHALL keep occupancy unchanged, including when full.
REQ-026 SHALL never overflow: credit rule in REQ-019 guarantees a slot for every outstanding response.
REQ-027 SHALL on redirect_in: empty FIFO same edge, load fetch PC with {redirect_addr_in[ARCH-1:2],2'b00}, set discard count = outstanding minus any rvalid that cycle, clear outstanding; instr_valid_out=0 the following cycle.
REQ-028 SHALL in FLUSH drop each rvalid response and decrement discard count; no requests issued in FLUSH.
REQ-029 SHALL give redirect_in priority over pop, push and grant in the same cycle; a grant coinciding with redirect_in SHALL NOT occur because imem_req_out=0 then.
REQ-030 SHALL treat redirect_in during FLUSH as: reload PC, discard count unchanged (minus rvalid that cycle).
REQ-031 SHALL size outstanding/discard counters $clog2(FIFO_DEPTH+1) bits.

Reset
REQ-032 SHALL on rst_n=0 immediately set state IDLE, fetch PC=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req_out=0, instr_valid_out=0, instr_out=0, instr_pc_out=0.
REQ-033 SHALL on reset mid-operation abandon all in-flight responses; the memory model must also be reset.
REQ-034 SHALL issue first request (imem_addr_out=RESET_PC) the first edge after rst_n rises with fetch_en_in=1.

Verification
REQ-035 Zero-wait memory, gnt=1, rvalid next cycle, ready=1 -> instructions at PCs 0x0,0x4,0x8,... one per cycle, no gaps after fill.
REQ-036 instr_ready_in=0, FIFO_DEPTH=4 -> exactly 4 grants, imem_req_out=0 thereafter, FIFO holds PCs 0x0-0xC; ready=1 -> drains in order, fetching resumes.
REQ-037 gnt held low 3 cycles -> imem_addr_out constant at 0x10 throughout, single grant counted.
REQ-038 Redirect to 0x103 with 2 outstanding -> 2 responses discarded, next request address 0x100, first output instr_pc_out=0x100.
REQ-039 Redirect coincident with pop and rvalid -> popped entry consumed once, rvalid data discarded, FIFO empty next cycle.
REQ-040 PC 0xFFFFFFFC granted -> next request address 0x00000000; rst_n pulse mid-burst -> all outputs 0 asynchronously, restart at RESET_PC.

Source files
------------

// File: rtl/friscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : friscv_fetch_unit
// Description : Instruction fetch front end. Issues sequential word requests
//               to instruction memory, collects in-order responses into a
//               prefetch FIFO and presents them to decode with a valid/ready
//               handshake. A redirect flushes the FIFO, restarts fetching at
//               the new target and silently drops responses that were still
//               in flight.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ARCH       : address / instruction width in bits
//   FIFO_DEPTH : prefetch buffer entries (power of two, >= 2)
//   RESET_PC   : first fetch address after reset (word aligned)
// Ports
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   fetch_en_in      in   allows new memory requests
//   imem_req_out     out  memory request valid
//   imem_addr_out    out  memory request word address
//   imem_gnt_in      in   request accepted this cycle
//   imem_rvalid_in   in   response valid (strictly in request order)
//   imem_rdata_in    in   response instruction word
//   redirect_in      in   taken branch/jump: flush and refetch
//   redirect_addr_in in   new fetch target
//   instr_valid_out  out  instr_out / instr_pc_out valid
//   instr_ready_in   in   decode accepts the presented instruction
//   instr_out        out  fetched instruction
//   instr_pc_out     out  address of instr_out
// ============================================================================
module friscv_fetch_unit #(
    parameter int              ARCH       = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [ARCH-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en_in,
    output logic            imem_req_out,
    output logic [ARCH-1:0] imem_addr_out,
    input  logic            imem_gnt_in,
    input  logic            imem_rvalid_in,
    input  logic [ARCH-1:0] imem_rdata_in,
    input  logic            redirect_in,
    input  logic [ARCH-1:0] redirect_addr_in,
    output logic            instr_valid_out,
    input  logic            instr_ready_in,
    output logic [ARCH-1:0] instr_out,
    output logic [ARCH-1:0] instr_pc_out
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w:0]   c_depth    = (c_cnt_w + 1)'(FIFO_DEPTH);
    localparam logic [ARCH-1:0]    c_pc_step  = ARCH'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ARCH-1:0]     r_pc;          // address of the next request
    logic [ARCH-1:0]     r_resp_pc;     // address of the oldest outstanding request
    logic [c_cnt_w-1:0]  r_outstanding; // granted, response not yet returned
    logic [c_cnt_w-1:0]  r_discard;     // stale responses still to be dropped

    logic [ARCH-1:0]     r_mem_instr [FIFO_DEPTH];
    logic [ARCH-1:0]     r_mem_pc    [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_grant;
    logic                w_resp_run;
    logic                w_push;
    logic                w_pop;
    logic [c_cnt_w:0]    w_credit_used;
    logic [c_cnt_w-1:0]  w_discard_base;
    logic [c_cnt_w-1:0]  w_discard_next;
    logic [ARCH-1:0]     w_redirect_pc;
    logic                w_unused_addr_lsb;

    // The target is forced to word alignment; the low bits carry no meaning.
    assign w_redirect_pc     = {redirect_addr_in[ARCH-1:2], 2'b00};
    assign w_unused_addr_lsb = ^redirect_addr_in[1:0];

    assign imem_addr_out   = r_pc;
    assign instr_valid_out = (r_count != '0);
    assign instr_out       = instr_valid_out ? r_mem_instr[r_rd_ptr] : '0;
    assign instr_pc_out    = instr_valid_out ? r_mem_pc[r_rd_ptr]    : '0;

    // Every in-flight request owns a FIFO slot, so the buffer can never
    // overflow regardless of how long decode stalls.
    assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};

    assign w_grant    = imem_req_out & imem_gnt_in;
    assign w_resp_run = imem_rvalid_in & (r_state == RUN) & (r_outstanding != '0);
    assign w_push     = w_resp_run & ~redirect_in;
    assign w_pop      = instr_valid_out & instr_ready_in & ~redirect_in;

    // ------------------------------------------------------------------------
    // Next state, request generation and discard bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        imem_req_out   = 1'b0;

        // Responses still owed by memory: in FLUSH these are the ones being
        // dropped, otherwise the live outstanding ones. A response arriving
        // this cycle is already accounted for.
        w_discard_base = (r_state == FLUSH) ? r_discard : r_outstanding;
        w_discard_next = w_discard_base;
        if (imem_rvalid_in && (w_discard_base != '0)) begin
            w_discard_next = w_discard_base - c_cnt_one;
        end

        if ((r_state == RUN) && fetch_en_in && !redirect_in &&
            (w_credit_used < c_depth)) begin
            imem_req_out = 1'b1;
        end

        if (redirect_in) begin
            if (w_discard_next != '0) begin
                w_state_next = FLUSH;
            end else if (fetch_en_in) begin
                w_state_next = RUN;
            end else begin
                w_state_next = IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_en_in) begin
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    if (!fetch_en_in && (r_outstanding == '0)) begin
                        w_state_next = IDLE;
                    end
                end
                FLUSH: begin
                    if (w_discard_next == '0) begin
                        w_state_next = fetch_en_in ? RUN : IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_state <= w_state_next;

            if (redirect_in) begin
                // Redirect wins over pop, push and grant in the same cycle.
                r_pc          <= w_redirect_pc;
                r_resp_pc     <= w_redirect_pc;
                r_outstanding <= '0;
                r_discard     <= w_discard_next;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
                r_count       <= '0;
            end else begin
                if (w_grant) begin
                    r_pc <= r_pc + c_pc_step;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + c_pc_step;
                end

                case ({w_grant, w_resp_run})
                    2'b10:   r_outstanding <= r_outstanding + c_cnt_one;
                    2'b01:   r_outstanding <= r_outstanding - c_cnt_one;
                    default: r_outstanding <= r_outstanding;
                endcase

                r_discard <= (r_state == FLUSH) ? w_discard_next : '0;

                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_one;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end

                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_one;
                    2'b01:   r_count <= r_count - c_cnt_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage; contents are only observable while occupancy is non-zero
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata_in;
            r_mem_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_friscv_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_friscv_fetch_unit
// Description : Directed bench for friscv_fetch_unit with an in-order
//               instruction memory model (response = ~address).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_friscv_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        redirect_in;
    logic [31:0] redirect_addr_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;

    always #5 clk = ~clk;

    friscv_fetch_unit #(
        .ARCH       (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_en_in      (fetch_en_in),
        .imem_req_out     (imem_req_out),
        .imem_addr_out    (imem_addr_out),
        .imem_gnt_in      (imem_gnt_in),
        .imem_rvalid_in   (imem_rvalid_in),
        .imem_rdata_in    (imem_rdata_in),
        .redirect_in      (redirect_in),
        .redirect_addr_in (redirect_addr_in),
        .instr_valid_out  (instr_valid_out),
        .instr_ready_in   (instr_ready_in),
        .instr_out        (instr_out),
        .instr_pc_out     (instr_pc_out)
    );

    int          errors = 0;
    int          checks = 0;
    int          grants = 0;
    logic        rsp_en;
    logic [31:0] mem_q[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then after the edge let the
    // memory model record grants and present the next in-order response.
    task automatic tick();
        logic        g;
        logic        p;
        logic [31:0] a;
        logic [31:0] ppc;
        logic [31:0] pins;
        logic [31:0] head;
        @(negedge clk);
        g    = imem_req_out & imem_gnt_in;
        a    = imem_addr_out;
        p    = instr_valid_out & instr_ready_in;
        ppc  = instr_pc_out;
        pins = instr_out;
        @(posedge clk);
        #1;
        if (g) begin
            mem_q.push_back(a);
            grants++;
        end
        if (p) begin
            pop_pc.push_back(ppc);
            pop_instr.push_back(pins);
        end
        if (rsp_en && (mem_q.size() > 0)) begin
            head           = mem_q.pop_front();
            imem_rvalid_in = 1'b1;
            imem_rdata_in  = ~head;
        end else begin
            imem_rvalid_in = 1'b0;
            imem_rdata_in  = 32'h0;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        fetch_en_in      = 1'b0;
        imem_gnt_in      = 1'b0;
        imem_rvalid_in   = 1'b0;
        imem_rdata_in    = 32'h0;
        redirect_in      = 1'b0;
        redirect_addr_in = 32'h0;
        instr_ready_in   = 1'b0;
        rsp_en           = 1'b0;
        mem_q.delete();
        pop_pc.delete();
        pop_instr.delete();
        grants = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- reset values ----------------
        rst_n            = 1'b0;
        fetch_en_in      = 1'b0;
        imem_gnt_in      = 1'b0;
        imem_rvalid_in   = 1'b0;
        imem_rdata_in    = 32'h0;
        redirect_in      = 1'b0;
        redirect_addr_in = 32'h0;
        instr_ready_in   = 1'b0;
        rsp_en           = 1'b0;
        #3;
        check("rst_req",   {31'h0, imem_req_out},    32'h0);
        check("rst_valid", {31'h0, instr_valid_out}, 32'h0);
        check("rst_instr", instr_out,                32'h0);
        check("rst_pc",    instr_pc_out,             32'h0);

        // ---------------- zero-wait streaming ----------------
        apply_reset();
        fetch_en_in    = 1'b1;
        imem_gnt_in    = 1'b1;
        instr_ready_in = 1'b1;
        rsp_en         = 1'b1;
        #1;
        check("idle_no_req", {31'h0, imem_req_out}, 32'h0);
        tick();
        check("first_req",  {31'h0, imem_req_out}, 32'h1);
        check("first_addr", imem_addr_out,         RST_PC);
        repeat (9) tick();
        check("stream_count", pop_pc.size(), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check("stream_pc",    pop_pc[i],    i * 4);
            check("stream_instr", pop_instr[i], ~(i * 4));
        end

        // ---------------- decode stall, credit limit ----------------
        apply_reset();
        fetch_en_in    = 1'b1;
        imem_gnt_in    = 1'b1;
        instr_ready_in = 1'b0;
        rsp_en         = 1'b1;
        repeat (10) tick();
        check("stall_grants", grants,                    32'd4);
        check("stall_req",    {31'h0, imem_req_out},     32'h0);
        check("stall_valid",  {31'h0, instr_valid_out},  32'h1);
        check("stall_head",   instr_pc_out,              32'h0);
        check("stall_addr",   imem_addr_out,             32'h10);
        instr_ready_in = 1'b1;
        repeat (6) tick();
        check("drain_count", pop_pc.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("drain_pc", pop_pc[i], i * 4);
        end

        // ---------------- grant held low ----------------
        apply_reset();
        fetch_en_in    = 1'b1;
        imem_gnt_in    = 1'b1;
        instr_ready_in = 1'b1;
        rsp_en         = 1'b1;
        repeat (5) tick();
        check("nogr_pre_grants", grants, 32'd4);
        imem_gnt_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("nogr_req",  {31'h0, imem_req_out}, 32'h1);
            check("nogr_addr", imem_addr_out,         32'h10);
            tick();
        end
        check("nogr_grants", grants, 32'd4);
        imem_gnt_in = 1'b1;
        check("nogr_addr_end", imem_addr_out, 32'h10);
        tick();
        check("nogr_one_grant", grants,        32'd5);
        check("nogr_next_addr", imem_addr_out, 32'h14);

        // ---------------- redirect with two outstanding ----------------
        apply_reset();
        fetch_en_in    = 1'b1;
        imem_gnt_in    = 1'b1;
        instr_ready_in = 1'b1;
        rsp_en         = 1'b0;
        repeat (3) tick();
        check("redir_out2", grants, 32'd2);
        redirect_in      = 1'b1;
        redirect_addr_in = 32'h103;
        #1;
        check("redir_req_off", {31'h0, imem_req_out}, 32'h0);
        tick();
        redirect_in = 1'b0;
        rsp_en      = 1'b1;
        #1;
        check("redir_valid_off", {31'h0, instr_valid_out}, 32'h0);
        check("flush_no_req",    {31'h0, imem_req_out},    32'h0);
        repeat (3) tick();
        check("redir_req",  {31'h0, imem_req_out}, 32'h1);
        check("redir_addr", imem_addr_out,         32'h100);
        repeat (2) tick();
        check("redir_valid",  {31'h0, instr_valid_out}, 32'h1);
        check("redir_pc",     instr_pc_out,             32'h100);
        check("redir_instr",  instr_out,                ~32'h100);
        check("redir_no_pop", pop_pc.size(),            32'd0);

        // ---------------- redirect with pop and rvalid together ----------------
        apply_reset();
        fetch_en_in    = 1'b1;
        imem_gnt_in    = 1'b1;
        instr_ready_in = 1'b1;
        rsp_en         = 1'b1;
        repeat (5) tick();
        check("coin_pre_pops", pop_pc.size(),  32'd2);
        check("coin_head",     instr_pc_out,   32'h8);
        check("coin_rvalid",   {31'h0, imem_rvalid_in}, 32'h1);
        redirect_in      = 1'b1;
        redirect_addr_in = 32'h200;
        tick();
        redirect_in = 1'b0;
        #1;
        check("coin_valid_off", {31'h0, instr_valid_out}, 32'h0);
        check("coin_pops",      pop_pc.size(),            32'd3);
        check("coin_pop_pc",    pop_pc[2],                32'h8);
        check("coin_req",       {31'h0, imem_req_out},    32'h1);
        check("coin_addr",      imem_addr_out,            32'h200);
        repeat (2) tick();
        check("coin_new_valid", {31'h0, instr_valid_out}, 32'h1);
        check("coin_new_pc",    instr_pc_out,             32'h200);
        check("coin_pops_end",  pop_pc.size(),            32'd3);

        // ---------------- PC wrap and asynchronous reset ----------------
        apply_reset();
        fetch_en_in      = 1'b1;
        imem_gnt_in      = 1'b1;
        instr_ready_in   = 1'b1;
        rsp_en           = 1'b1;
        redirect_in      = 1'b1;
        redirect_addr_in = 32'hFFFF_FFFC;
        tick();
        redirect_in = 1'b0;
        #1;
        check("wrap_req",  {31'h0, imem_req_out}, 32'h1);
        check("wrap_addr", imem_addr_out,         32'hFFFF_FFFC);
        tick();
        check("wrap_next_addr", imem_addr_out, 32'h0);
        tick();
        check("wrap_valid", {31'h0, instr_valid_out}, 32'h1);
        check("wrap_pc",    instr_pc_out,             32'hFFFF_FFFC);
        check("wrap_instr", instr_out,                32'h3);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_req",   {31'h0, imem_req_out},    32'h0);
        check("arst_valid", {31'h0, instr_valid_out}, 32'h0);
        check("arst_instr", instr_out,                32'h0);
        check("arst_pc",    instr_pc_out,             32'h0);
        imem_rvalid_in = 1'b0;
        imem_rdata_in  = 32'h0;
        mem_q.delete();
        tick();
        rst_n = 1'b1;
        #1;
        check("restart_idle", {31'h0, imem_req_out}, 32'h0);
        tick();
        check("restart_req",  {31'h0, imem_req_out}, 32'h1);
        check("restart_addr", imem_addr_out,         RST_PC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
